// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants and types for the text-mode pixel pipeline
// Contents: glyph cell geometry, pipeline latency, text-cell field positions,
//           packed text-cell and 3-bit colour types, glyph ROM address helper.
package vga_text_pkg;

  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;
  localparam int PIPE_LAT = 5;

  // Text RAM word layout
  localparam int CHAR_LSB = 0;
  localparam int CHAR_MSB = 7;
  localparam int FG_LSB   = 8;
  localparam int BG_LSB   = 11;

  typedef logic [2:0] rgb3_t;

  typedef struct packed {
    logic [1:0] spare;
    rgb3_t      bg;
    rgb3_t      fg;
    logic [7:0] ch;
  } text_cell_t;

  // {char, row-in-glyph, column-in-glyph} is 15 bits; the ROM port is 14 bits,
  // so the char MSB falls off the top.
  function automatic logic [13:0] glyph_index(input logic [7:0] ch,
                                              input logic [3:0] gy,
                                              input logic [2:0] gx);
    logic [14:0] full;
    full = {ch, gy, gx};
    return full[13:0];
  endfunction

endpackage

// File: rtl/text_cursor_blink.sv
// rtl/text_cursor_blink.sv - 5-bit frame counter giving the cursor blink phase
// Ports:
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   frame_tick in   one-cycle pulse at the first pixel of each frame
//   phase      out  blink phase, toggles every 16 frames
module text_cursor_blink (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  output logic phase
);

  logic [4:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 5'd1;
    end
  end

  assign phase = frame_cnt[4];

endmodule

// File: rtl/text_pixel_pipeline.sv
// rtl/text_pixel_pipeline.sv - text-mode pixel stage: position -> text RAM -> glyph ROM -> rgb
// Optional feature macro: TEXT_CURSOR_EN (blinking underline cursor).
// Ports:
//   pixel_clk, rst_n        clock, asynchronous active-low reset
//   h_pos, v_pos            beam position from the timing controller
//   h_sync_i, v_sync_i      raw syncs from the timing controller
//   txt_addr, txt_data      text RAM port (1-cycle read latency)
//   glyph_addr, glyph_bit   glyph ROM port (1-cycle read latency)
//   h_sync_o, v_sync_o      syncs delayed to line up with r/g/b
//   r, g, b                 pixel colour
//   cursor_col, cursor_row  cursor cell (TEXT_CURSOR_EN builds only)
module text_pixel_pipeline
  import vga_text_pkg::*;
#(
  parameter int   H_ACTIVE  = 800,
  parameter int   V_ACTIVE  = 600,
  parameter int   COLS      = 100,
  parameter int   ROWS      = 37,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [10:0] h_pos,
  input  logic [10:0] v_pos,
  input  logic        h_sync_i,
  input  logic        v_sync_i,
  output logic [11:0] txt_addr,
  input  logic [15:0] txt_data,
  output logic [13:0] glyph_addr,
  input  logic        glyph_bit,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        r,
  output logic        g,
  output logic        b
`ifdef TEXT_CURSOR_EN
  ,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row
`endif
);

  // Lines below the last full text row are blank even inside V_ACTIVE.
  localparam int          TEXT_LINES = (ROWS * CHAR_H < V_ACTIVE) ? ROWS * CHAR_H : V_ACTIVE;
  localparam logic [11:0] COLS12     = 12'(COLS);

  logic [11:0] row_base;
  logic [11:0] addr_next;
  logic        active;
  logic        cur_hit;
  logic        unused_txt_bits;

  assign row_base        = {5'd0, v_pos[10:4]} * COLS12;
  assign addr_next       = row_base + {4'd0, h_pos[10:3]};
  assign active          = (h_pos < 11'(H_ACTIVE)) && (v_pos < 11'(TEXT_LINES));
  assign unused_txt_bits = ^txt_data[15:14];

`ifdef TEXT_CURSOR_EN
  logic frame_tick;
  logic blink_phase;

  assign frame_tick = (h_pos == 11'd0) && (v_pos == 11'd0);

  text_cursor_blink u_blink (
    .clk        (pixel_clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .phase      (blink_phase)
  );

  // Cursor is the bottom two glyph lines of the cursor cell; the blink phase is
  // captured with the cell so a frame tick later in the pipe cannot split a pixel.
  assign cur_hit = blink_phase
                && ({1'b0, cursor_row} == v_pos[10:4])
                && ({1'b0, cursor_col} == h_pos[10:3])
                && (v_pos[3:1] == 3'b111);
`else
  assign cur_hit = 1'b0;
`endif

  // S1: text RAM address, glyph coordinates, flags
  logic [2:0] s1_x;
  logic [3:0] s1_y;
  logic       s1_act, s1_hs, s1_vs, s1_cur;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      txt_addr <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_act   <= 1'b0;
      s1_hs    <= SYNC_IDLE;
      s1_vs    <= SYNC_IDLE;
      s1_cur   <= 1'b0;
    end else begin
      txt_addr <= addr_next;
      s1_x     <= h_pos[2:0];
      s1_y     <= v_pos[3:0];
      s1_act   <= active;
      s1_hs    <= h_sync_i;
      s1_vs    <= v_sync_i;
      s1_cur   <= cur_hit;
    end
  end

  // S2: wait for the text RAM read
  logic [2:0] s2_x;
  logic [3:0] s2_y;
  logic       s2_act, s2_hs, s2_vs, s2_cur;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_x   <= '0;
      s2_y   <= '0;
      s2_act <= 1'b0;
      s2_hs  <= SYNC_IDLE;
      s2_vs  <= SYNC_IDLE;
      s2_cur <= 1'b0;
    end else begin
      s2_x   <= s1_x;
      s2_y   <= s1_y;
      s2_act <= s1_act;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_cur <= s1_cur;
    end
  end

  // S3: text cell is on txt_data now; issue the glyph ROM address
  rgb3_t s3_fg, s3_bg;
  logic  s3_act, s3_hs, s3_vs, s3_cur;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_addr <= '0;
      s3_fg      <= '0;
      s3_bg      <= '0;
      s3_act     <= 1'b0;
      s3_hs      <= SYNC_IDLE;
      s3_vs      <= SYNC_IDLE;
      s3_cur     <= 1'b0;
    end else begin
      glyph_addr <= glyph_index(txt_data[CHAR_MSB:CHAR_LSB], s2_y, s2_x);
      s3_fg      <= txt_data[FG_LSB +: 3];
      s3_bg      <= txt_data[BG_LSB +: 3];
      s3_act     <= s2_act;
      s3_hs      <= s2_hs;
      s3_vs      <= s2_vs;
      s3_cur     <= s2_cur;
    end
  end

  // S4: wait for the glyph ROM read
  rgb3_t s4_fg, s4_bg;
  logic  s4_act, s4_hs, s4_vs, s4_cur;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      s4_fg  <= '0;
      s4_bg  <= '0;
      s4_act <= 1'b0;
      s4_hs  <= SYNC_IDLE;
      s4_vs  <= SYNC_IDLE;
      s4_cur <= 1'b0;
    end else begin
      s4_fg  <= s3_fg;
      s4_bg  <= s3_bg;
      s4_act <= s3_act;
      s4_hs  <= s3_hs;
      s4_vs  <= s3_vs;
      s4_cur <= s3_cur;
    end
  end

  // S5: colour the glyph bit
  rgb3_t pix;

  always_comb begin
    pix = glyph_bit ? s4_fg : s4_bg;
    if (s4_cur) pix = s4_fg;
    if (!s4_act) pix = 3'b000;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      {r, g, b} <= 3'b000;
      h_sync_o  <= SYNC_IDLE;
      v_sync_o  <= SYNC_IDLE;
    end else begin
      {r, g, b} <= pix;
      h_sync_o  <= s4_hs;
      v_sync_o  <= s4_vs;
    end
  end

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// tb/tb_text_pixel_pipeline.sv - self-checking bench for text_pixel_pipeline
module tb_text_pixel_pipeline;

`ifdef TEXT_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  logic        pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] h_pos = '0;
  logic [10:0] v_pos = '0;
  logic        h_sync_i = 1'b1;
  logic        v_sync_i = 1'b1;
  logic [11:0] txt_addr;
  logic [15:0] txt_data = '0;
  logic [13:0] glyph_addr;
  logic        glyph_bit = 1'b0;
  logic        h_sync_o, v_sync_o, r, g, b;
  logic [6:0]  cursor_col = 7'd2;
  logic [5:0]  cursor_row = 6'd7;

  text_pixel_pipeline dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .h_pos      (h_pos),
    .v_pos      (v_pos),
    .h_sync_i   (h_sync_i),
    .v_sync_i   (v_sync_i),
    .txt_addr   (txt_addr),
    .txt_data   (txt_data),
    .glyph_addr (glyph_addr),
    .glyph_bit  (glyph_bit),
    .h_sync_o   (h_sync_o),
    .v_sync_o   (v_sync_o),
    .r          (r),
    .g          (g),
    .b          (b)
`ifdef TEXT_CURSOR_EN
    ,
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
`endif
  );

  always #20 pixel_clk = ~pixel_clk;

  logic [15:0] mem [0:4095];
  logic        rom [0:16383];

  always @(posedge pixel_clk) begin
    txt_data  <= mem[txt_addr];
    glyph_bit <= rom[glyph_addr];
  end

  typedef struct packed {
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic [15:0] tag;
  } exp_t;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
    logic [11:0] ta;
    logic        ga_en;
    logic [13:0] ga;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[8];
  int   errors = 0;
  int   checks = 0;
  int   ticks  = 0;

  function automatic int gidx(input int ch, input int gy, input int gx);
    return (ch * 128 + gy * 8 + gx) % 16384;
  endfunction

  function automatic logic [2:0] model_rgb(input int h, input int v, input bit phase);
    logic [15:0] c;
    if (h >= 800 || v >= 592) return 3'b000;
    c = mem[(v / 16) * 100 + h / 8];
    if (CUR_EN && phase && (v / 16) == int'(cursor_row) && (h / 8) == int'(cursor_col) && (v % 16) >= 14)
      return c[10:8];
    return rom[gidx(int'(c[7:0]), v % 16, h % 8)] ? c[10:8] : c[13:11];
  endfunction

  function automatic vec_t mkvec(input int h, input int v, input logic hs, input logic vs,
                                 input logic [2:0] rgb, input int ta, input logic ga_en, input int ga);
    vec_t t;
    t.h = 11'(h); t.v = 11'(v); t.hs = hs; t.vs = vs; t.rgb = rgb;
    t.ta = 12'(ta); t.ga_en = ga_en; t.ga = 14'(ga);
    return t;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Drive one pixel, push its expectation, advance a clock and compare the
  // output that is due now (the queue always holds the 4 in-flight pixels).
  task automatic step(input int h, input int v, input logic hs, input logic vs,
                      input logic [2:0] erg, input int tag);
    exp_t e;
    h_pos = 11'(h); v_pos = 11'(v); h_sync_i = hs; v_sync_i = vs;
    e.rgb = erg; e.hs = hs; e.vs = vs; e.tag = 16'(tag);
    sbq.push_back(e);
    if (h == 0 && v == 0) ticks = (ticks + 1) % 32;
    @(posedge pixel_clk);
    #1;
    e = sbq.pop_front();
    checks++;
    if ({r, g, b} !== e.rgb || h_sync_o !== e.hs || v_sync_o !== e.vs) begin
      errors++;
      $display("FAIL pix tag=%0d got rgb=%b hs=%b vs=%b expected rgb=%b hs=%b vs=%b",
               e.tag, {r, g, b}, h_sync_o, v_sync_o, e.rgb, e.hs, e.vs);
    end
  endtask

  task automatic pix(input int h, input int v, input logic hs, input logic vs, input int tag);
    step(h, v, hs, vs, model_rgb(h, v, ticks[4]), tag);
  endtask

  task automatic reset_dut(input string name);
    exp_t e;
    rst_n = 1'b0;
    #1;
    check({name, "_outputs"}, int'({txt_addr, glyph_addr, r, g, b, h_sync_o, v_sync_o}),
          int'({12'd0, 14'd0, 3'b000, 1'b1, 1'b1}));
    @(posedge pixel_clk); #1;
    @(posedge pixel_clk); #1;
    rst_n = 1'b1;
    ticks = 0;
    sbq.delete();
    e.rgb = 3'b000; e.hs = 1'b1; e.vs = 1'b1; e.tag = 16'hFFFF;
    for (int i = 0; i < 4; i++) sbq.push_back(e);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 16384; i++) rom[i] = 1'($urandom);
    mem[0]    = 16'h0A43;   // char 0x43, fg 010, bg 001
    mem[3699] = 16'h1D41;   // char 0x41, fg 101, bg 011
    mem[100]  = 16'h3F7F;   // off-screen cells with an all-ones glyph
    mem[3700] = 16'h3F7F;
    mem[3800] = 16'h3F7F;
    mem[702]  = 16'h0A43;   // cursor cell (col 2, row 7)
    for (int i = 0; i < 128; i++) rom[gidx(8'h7F, i / 8, i % 8)] = 1'b1;
    rom[gidx(8'h43, 5, 3)]  = 1'b1;
    rom[gidx(8'h43, 5, 2)]  = 1'b0;
    rom[gidx(8'h43, 0, 7)]  = 1'b1;
    rom[gidx(8'h43, 14, 0)] = 1'b0;
    rom[gidx(8'h41, 15, 7)] = 1'b1;
    rom[gidx(8'h41, 15, 6)] = 1'b0;

    tbl[0] = mkvec(3,   5,   1, 1, 3'b010, 0,    1, 14'h21AB);
    tbl[1] = mkvec(2,   5,   0, 1, 3'b001, 0,    1, 14'h21AA);
    tbl[2] = mkvec(799, 591, 1, 0, 3'b101, 3699, 1, 14'h20FF);
    tbl[3] = mkvec(798, 591, 0, 0, 3'b011, 3699, 1, 14'h20FE);
    tbl[4] = mkvec(800, 0,   1, 1, 3'b000, 100,  1, 14'h3F80);
    tbl[5] = mkvec(0,   592, 0, 1, 3'b000, 3700, 1, 14'h3F80);
    tbl[6] = mkvec(801, 599, 1, 0, 3'b000, 3800, 1, 14'h3FB9);
    tbl[7] = mkvec(7,   0,   1, 1, 3'b010, 0,    1, 14'h2187);

    @(posedge pixel_clk); #1;
    reset_dut("reset");

    // Directed vectors: colour, address timing and blanking boundaries
    for (int i = 0; i < 8; i++) begin
      step(int'(tbl[i].h), int'(tbl[i].v), tbl[i].hs, tbl[i].vs, tbl[i].rgb, i);
      check($sformatf("txt_addr[%0d]", i), int'(txt_addr), int'(tbl[i].ta));
      if (i >= 2 && tbl[i-2].ga_en)
        check($sformatf("glyph_addr[%0d]", i - 2), int'(glyph_addr), int'(tbl[i-2].ga));
    end
    for (int i = 8; i < 10; i++) begin
      pix(i * 8, 40, 1'b1, 1'b1, 100 + i);
      check($sformatf("glyph_addr[%0d]", i - 2), int'(glyph_addr), int'(tbl[i-2].ga));
    end

    // Sync toggling: outputs must follow with the colour
    for (int i = 0; i < 12; i++) pix(i * 8 + 1, 20, i[0], i[1], 200 + i);

    // Reset in the middle of a line
    for (int i = 0; i < 3; i++) pix(300 + i, 50, 1'b0, 1'b0, 300 + i);
    reset_dut("midline_reset");
    step(3, 5, 1'b0, 1'b1, 3'b010, 400);
    for (int i = 1; i < 8; i++) pix(i, 5, 1'b0, 1'b1, 400 + i);

`ifdef TEXT_CURSOR_EN
    // Cursor blink: 16 frame ticks turn it on, 16 more turn it off
    for (int i = 0; i < 16; i++) pix(0, 0, 1'b1, 1'b1, 500 + i);
    step(16, 126, 1'b1, 1'b1, 3'b010, 520);
    for (int i = 0; i < 16; i++) pix(0, 0, 1'b1, 1'b1, 530 + i);
    step(16, 126, 1'b1, 1'b1, 3'b001, 550);
`endif

    // Sampled frame sweep against the reference model
    for (int k = 0; k < 38; k++) begin
      int v;
      v = (k < 36) ? k * 17 : ((k == 36) ? 591 : 599);
      for (int h = 0; h < 810; h++)
        pix(h, v, !(h >= 802 && h < 806), !(v >= 595), 1000 + k);
    end
    for (int i = 0; i < 4; i++) pix(0, 1, 1'b1, 1'b1, 2000 + i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
